// File: rtl/mux_2x1_if.sv
// mux_2x1_if: data legs, select and result bundle for mux_2x1
interface mux_2x1_if #(parameter int W = 1);
  logic [2*W-1:0] din;
  logic sel;
  logic [W-1:0] dout;
  logic dout_vld;
  modport master (output din, sel, input dout, dout_vld);
  modport slave (input din, sel, output dout, dout_vld);
endinterface

// File: rtl/mux_2x1.sv
// mux_2x1: selects one of two W-bit legs, registered or combinational
module mux_2x1 #(
  parameter int W = 1,
  parameter bit REG_OUT = 1
) (
  input logic clk,
  input logic rst,
  mux_2x1_if.slave bus
);
  logic [W-1:0] pick;
  assign pick = bus.sel ? bus.din[2*W-1:W] : bus.din[W-1:0];
  if (REG_OUT) begin : g_reg
    logic [W-1:0] q;
    logic v;
    always_ff @(posedge clk) begin
      q <= rst ? '0 : pick;
      v <= !rst;
    end
    assign bus.dout = q;
    assign bus.dout_vld = v;
  end else begin : g_comb
    logic unused;
    assign unused = clk ^ rst;
    assign bus.dout = pick;
    assign bus.dout_vld = 1'b1;
  end
endmodule

// File: tb/tb_mux_2x1.sv
// tb_mux_2x1: directed checks of registered W=1 and combinational W=8 muxes
module tb_mux_2x1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mux_2x1_if #(.W(1)) b1 ();
  mux_2x1_if #(.W(8)) b8 ();
  mux_2x1 #(.W(1), .REG_OUT(1)) dut_reg (.clk(clk), .rst(rst), .bus(b1));
  mux_2x1 #(.W(8), .REG_OUT(0)) dut_comb (.clk(clk), .rst(rst), .bus(b8));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [7:0] sweep_exp;
  initial begin
    sweep_exp = 8'b1110_0100;
    b1.din = 2'b11;
    b1.sel = 1'b1;
    b8.din = '0;
    b8.sel = 1'b0;
    tick();
    chk("rst1_dout", 64'(b1.dout), 64'd0);
    chk("rst1_vld", 64'(b1.dout_vld), 64'd0);
    tick();
    chk("rst2_dout", 64'(b1.dout), 64'd0);
    chk("rst2_vld", 64'(b1.dout_vld), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_dout", 64'(b1.dout), 64'd1);
    chk("post_rst_vld", 64'(b1.dout_vld), 64'd1);
    for (int i = 0; i < 8; i++) begin
      b1.din = 2'(i >> 1);
      b1.sel = i[0];
      tick();
      chk($sformatf("sweep_d%0d_s%0d", i >> 1, i & 1), 64'(b1.dout), 64'(sweep_exp[i]));
    end
    b1.din = 2'b10;
    for (int i = 0; i < 8; i++) begin
      b1.sel = i[0];
      tick();
      chk($sformatf("toggle_%0d", i), 64'(b1.dout), 64'(i & 1));
    end
    b1.din = 2'b01;
    b1.sel = 1'b0;
    tick();
    chk("simul_before", 64'(b1.dout), 64'd1);
    b1.din = 2'b10;
    b1.sel = 1'b1;
    tick();
    chk("simul_after", 64'(b1.dout), 64'd1);
    b1.din = 2'b11;
    b1.sel = 1'b0;
    tick();
    chk("mid_steady_dout", 64'(b1.dout), 64'd1);
    chk("mid_steady_vld", 64'(b1.dout_vld), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_dout", 64'(b1.dout), 64'd0);
    chk("mid_rst_vld", 64'(b1.dout_vld), 64'd0);
    chk("comb_vld_in_rst", 64'(b8.dout_vld), 64'd1);
    rst = 1'b0;
    tick();
    chk("mid_rel_dout", 64'(b1.dout), 64'd1);
    chk("mid_rel_vld", 64'(b1.dout_vld), 64'd1);
    b8.din = 16'hA55A;
    b8.sel = 1'b0;
    #1;
    chk("comb_sel0", 64'(b8.dout), 64'h5A);
    b8.sel = 1'b1;
    #1;
    chk("comb_sel1", 64'(b8.dout), 64'hA5);
    chk("comb_vld", 64'(b8.dout_vld), 64'd1);
    b8.din = 16'h1234;
    #1;
    chk("comb_din_chg", 64'(b8.dout), 64'h12);
    b8.sel = 1'b0;
    #1;
    chk("comb_sel0_b", 64'(b8.dout), 64'h34);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mux_2x1.md
MUX_2X1 -- requirements
Module: mux_2x1

Interface
REQ-001 Parameter W, default 1: bit width of each data leg; legal range 1..64.
REQ-002 Parameter REG_OUT, default 1: 1 = registered output; 0 = combinational output.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 din  input  2*W  packed data legs:
  - leg 0 = din[W-1:0]
  - leg 1 = din[2*W-1:W]
REQ-006 sel  input  1  leg select: 0 selects leg 0, 1 selects leg 1.
REQ-007 dout  output  W  selected data.
REQ-008 dout_vld  output  1  dout holds a valid selection result.

Function
REQ-009 Selection rule: result = leg 0 when sel=0, leg 1 when sel=1.
  - Bit order preserved; no inversion, no extension.
  - With W=1: sel=0 gives din[0], sel=1 gives din[1].
REQ-010 REG_OUT=1: at each rising clk edge with rst=0:
  - dout <= selection result of the din/sel values sampled at that edge.
  - Latency is exactly 1 cycle.
  - No enable; dout reloads every cycle.
REQ-011 REG_OUT=0: dout equals the selection result combinationally, with zero-cycle latency.
  - dout ignores clk and rst.
  - dout_vld stays tied to 1.
REQ-012 din and sel changes are fully independent; simultaneous changes of both in one cycle are legal.
  - The next dout reflects the new sel applied to the new din.
REQ-013 No glitch filtering or hold-off: a sel toggle every cycle produces a dout update every cycle (REG_OUT=1).
REQ-014 An unknown (X/Z) sel has no defined response. A synthesized implementation maps it to either leg, with no other side effect.
REQ-015 No internal state beyond the dout register and the dout_vld flag.
REQ-016 The design is purely synthesizable. It contains no latches and no clock gating.

Reset
REQ-017 rst=1 at a rising clk edge (REG_OUT=1) forces:
  - dout = 0 (all W bits).
  - dout_vld = 0.
REQ-018 Reset takes priority over selection at the same edge. din/sel at that edge are discarded.
REQ-019 At the first rising edge with rst=0:
  - dout loads the current selection.
  - dout_vld = 1 and stays 1 until the next reset.
REQ-020 Reset asserted mid-stream clears dout and dout_vld at the next edge, with no residual of prior data.
REQ-021 Outputs before the first reset edge are undefined. Benches assert rst for at least 1 cycle at start.

Verification
REQ-022 Reset: rst=1 for 2 cycles with din=2'b11, sel=1 -> dout=0, dout_vld=0; first edge after rst=0 -> dout=1, dout_vld=1.
REQ-023 Exhaustive sweep (W=1, REG_OUT=1): din 00,01,10,11 x sel 0,1 -> dout one cycle later = 0,0 / 1,0 / 0,1 / 1,1.
REQ-024 Toggle: din=2'b10, sel alternating 0/1 every cycle -> dout alternates 0/1 with a one-cycle lag.
REQ-025 Simultaneous change: din 01->10 and sel 0->1 at the same edge -> dout=1 next cycle.
REQ-026 Mid-stream reset: steady din=2'b11, sel=0, then rst pulsed 1 cycle -> dout=0, dout_vld=0 for that cycle, then dout=1.
REQ-027 Width/combinational: W=8, REG_OUT=0, din=16'hA55A:
  - sel=0 -> dout=8'h5A immediately.
  - sel=1 -> dout=8'hA5 immediately.
